// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the program loader
package loader_pkg;

    // Frame-parsing states of the loader FSM.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LENGTH,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    localparam logic [7:0] DEFAULT_START_BYTE        = 8'hA5;
    localparam int         DEFAULT_INSTRUCTION_WIDTH = 32;
    localparam int         BYTES_PER_WORD            = DEFAULT_INSTRUCTION_WIDTH / 8;

    // Words loaded for a zero length byte: the whole memory, at most 256.
    function automatic int max_words(input int pc_width);
        return (pc_width >= 8) ? 256 : (1 << pc_width);
    endfunction

endpackage

// File: rtl/loader_word_packer.sv
// rtl/loader_word_packer.sv - assembles MSB-first bytes into instruction words
//
// Ports:
//   clock, isResetN : clock and synchronous active-low reset
//   clear           : restart assembly at the first byte of a word
//   byteValid       : dataByte is consumed this cycle
//   dataByte        : incoming byte
//   word            : assembled word including the current byte (combinational)
//   wordValid       : the current byte completes a word (combinational)
module loader_word_packer #(
    parameter int BYTES = 4
) (
    input  logic               clock,
    input  logic               isResetN,
    input  logic               clear,
    input  logic               byteValid,
    input  logic [7:0]         dataByte,
    output logic [BYTES*8-1:0] word,
    output logic               wordValid
);

    localparam int W  = BYTES * 8;
    localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [CW-1:0] count;
    logic          last_byte;

    assign last_byte = (count == CW'(BYTES - 1));
    assign wordValid = byteValid && last_byte;

    always_ff @(posedge clock) begin
        if (!isResetN || clear) begin
            count <= '0;
        end else if (byteValid) begin
            count <= last_byte ? '0 : count + 1'b1;
        end
    end

    generate
        if (BYTES > 1) begin : g_multi
            // Earlier bytes of the word; the newest byte goes in at the bottom.
            logic [W-9:0] shift;

            assign word = {shift, dataByte};

            always_ff @(posedge clock) begin
                if (!isResetN || clear) begin
                    shift <= '0;
                end else if (byteValid) begin
                    shift <= word[W-9:0];
                end
            end
        end else begin : g_single
            assign word = dataByte;
        end
    endgenerate

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - loads a framed byte stream into instruction memory
//
// Ports:
//   clock, isResetN         : clock and synchronous active-low reset
//   rxData, rxValid, rxReady: byte stream in, accepted on rxValid & rxReady
//   memWriteEnable          : one-cycle instruction-memory write strobe
//   memAddress, memWriteData: write address and data, stable with the strobe
//   cpuHold                 : holds the CPU in reset while a frame loads
//   loadDone                : one-cycle pulse after a good checksum
//   loadError               : level, last frame failed its checksum
module program_loader
    import loader_pkg::*;
#(
    parameter int         INSTRUCTION_WIDTH = 32,
    parameter int         PC_WIDTH          = 8,
    parameter logic [7:0] START_BYTE        = DEFAULT_START_BYTE
) (
    input  logic                         clock,
    input  logic                         isResetN,
    input  logic [7:0]                   rxData,
    input  logic                         rxValid,
    output logic                         rxReady,
    output logic                         memWriteEnable,
    output logic [PC_WIDTH-1:0]          memAddress,
    output logic [INSTRUCTION_WIDTH-1:0] memWriteData,
    output logic                         cpuHold,
    output logic                         loadDone,
    output logic                         loadError
);

    localparam int WORD_BYTES = INSTRUCTION_WIDTH / 8;
    localparam int MAX_WORDS  = max_words(PC_WIDTH);

    loader_state_t                  state;
    logic [7:0]                     checksum;
    logic [7:0]                     length;
    logic [8:0]                     words_done;
    logic [8:0]                     target;
    logic                           accept;
    logic                           start_seen;
    logic                           data_byte;
    logic [INSTRUCTION_WIDTH-1:0]   word;
    logic                           word_valid;

    assign accept     = rxValid && rxReady;
    assign start_seen = accept && (rxData == START_BYTE) &&
                        ((state == ST_IDLE) || (state == ST_ERROR));
    assign data_byte  = accept && (state == ST_DATA);
    assign target     = (length == 8'd0) ? 9'(MAX_WORDS) : {1'b0, length};

    loader_word_packer #(
        .BYTES(WORD_BYTES)
    ) u_packer (
        .clock    (clock),
        .isResetN (isResetN),
        .clear    (start_seen),
        .byteValid(data_byte),
        .dataByte (rxData),
        .word     (word),
        .wordValid(word_valid)
    );

    always_ff @(posedge clock) begin
        if (!isResetN) begin
            state          <= ST_IDLE;
            rxReady        <= 1'b0;
            memWriteEnable <= 1'b0;
            memAddress     <= '0;
            memWriteData   <= '0;
            cpuHold        <= 1'b0;
            loadDone       <= 1'b0;
            loadError      <= 1'b0;
            checksum       <= '0;
            length         <= '0;
            words_done     <= '0;
        end else begin
            rxReady        <= 1'b1;
            loadDone       <= 1'b0;
            memWriteEnable <= word_valid;
            if (word_valid) begin
                memWriteData <= word;
            end
            // Address moves on only once the strobe for it has been seen.
            if (memWriteEnable) begin
                memAddress <= memAddress + 1'b1;
            end

            case (state)
                ST_IDLE, ST_ERROR: begin
                    if (start_seen) begin
                        state      <= ST_LENGTH;
                        cpuHold    <= 1'b1;
                        loadError  <= 1'b0;
                        checksum   <= '0;
                        words_done <= '0;
                        memAddress <= '0;
                    end
                end
                ST_LENGTH: begin
                    if (accept) begin
                        length <= rxData;
                        state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        checksum <= checksum + rxData;
                        if (word_valid) begin
                            words_done <= words_done + 9'd1;
                            if (words_done + 9'd1 == target) begin
                                state <= ST_CHECK;
                            end
                        end
                    end
                end
                ST_CHECK: begin
                    if (accept) begin
                        if (rxData == checksum) begin
                            state    <= ST_DONE;
                            loadDone <= 1'b1;
                            cpuHold  <= 1'b0;
                            rxReady  <= 1'b0;
                        end else begin
                            state     <= ST_ERROR;
                            loadError <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized scoreboard bench for program_loader
module tb_program_loader;

    localparam int IW = 32;
    localparam int PW = 8;

    logic          clock = 1'b0;
    logic          isResetN = 1'b0;
    logic [7:0]    rxData = 8'h00;
    logic          rxValid = 1'b0;
    logic          rxReady;
    logic          memWriteEnable;
    logic [PW-1:0] memAddress;
    logic [IW-1:0] memWriteData;
    logic          cpuHold;
    logic          loadDone;
    logic          loadError;

    int checks = 0;
    int errors = 0;
    int done_expected = 0;
    int done_seen = 0;

    logic [PW+IW-1:0] wq[$];
    logic [IW-1:0]    frame_words[$];

    program_loader #(
        .INSTRUCTION_WIDTH(IW),
        .PC_WIDTH         (PW),
        .START_BYTE       (8'hA5)
    ) dut (
        .clock         (clock),
        .isResetN      (isResetN),
        .rxData        (rxData),
        .rxValid       (rxValid),
        .rxReady       (rxReady),
        .memWriteEnable(memWriteEnable),
        .memAddress    (memAddress),
        .memWriteData  (memWriteData),
        .cpuHold       (cpuHold),
        .loadDone      (loadDone),
        .loadError     (loadError)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue.
    always @(negedge clock) begin
        logic [PW+IW-1:0] e;
        if (memWriteEnable) begin
            if (wq.size() == 0) begin
                check("unexpected_write", {memAddress, memWriteData}, 64'h0);
            end else begin
                e = wq.pop_front();
                check("write_addr", 64'(memAddress), 64'(e[PW+IW-1:IW]));
                check("write_data", 64'(memWriteData), 64'(e[IW-1:0]));
            end
        end
        if (loadDone) begin
            check("done_expected", 64'(done_seen < done_expected), 64'd1);
            check("hold_low_at_done", 64'(cpuHold), 64'd0);
            done_seen++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
            end
        end
        n = 0;
        while (!rxReady && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 100) check("ready_timeout", 64'(n), 64'd0);
        rxData  = b;
        rxValid = 1'b1;
        @(posedge clock);
        #1;
        rxValid = 1'b0;
    endtask

    // Model: payload words go to addresses 0..N-1, checksum is the byte sum.
    task automatic send_frame(input int len_byte, input bit bad, input bit gaps);
        int          nw;
        int          n;
        logic [7:0]  sum;
        logic [7:0]  lb;
        logic [IW-1:0] w;
        nw = (len_byte == 0) ? 256 : len_byte;
        while (frame_words.size() < nw) frame_words.push_back($urandom);
        sum = 8'h00;
        lb  = len_byte[7:0];
        send_byte(8'hA5, gaps);
        check("hold_after_start", 64'(cpuHold), 64'd1);
        check("error_cleared", 64'(loadError), 64'd0);
        send_byte(lb, gaps);
        for (int i = 0; i < nw; i++) begin
            w = frame_words[i];
            wq.push_back({PW'(i), w});
            for (int k = IW / 8 - 1; k >= 0; k--) begin
                sum = sum + w[k*8 +: 8];
                send_byte(w[k*8 +: 8], gaps);
            end
        end
        check("hold_before_check", 64'(cpuHold), 64'd1);
        if (!bad) done_expected++;
        send_byte(bad ? sum + 8'd1 : sum, gaps);
        if (!bad) begin
            n = 0;
            while (done_seen != done_expected && n < 10) begin
                @(posedge clock);
                #1;
                n++;
            end
            check("done_timeout", 64'(done_seen), 64'(done_expected));
            check("hold_after_done", 64'(cpuHold), 64'd0);
            check("no_error_after_done", 64'(loadError), 64'd0);
        end else begin
            check("error_set", 64'(loadError), 64'd1);
            repeat (3) @(posedge clock);
            #1;
            check("error_held", 64'(loadError), 64'd1);
            check("hold_in_error", 64'(cpuHold), 64'd1);
        end
        frame_words.delete();
    endtask

    task automatic check_reset_outputs(input logic exp_ready);
        check("rst_ready", 64'(rxReady), 64'(exp_ready));
        check("rst_we", 64'(memWriteEnable), 64'd0);
        check("rst_addr", 64'(memAddress), 64'd0);
        check("rst_data", 64'(memWriteData), 64'd0);
        check("rst_hold", 64'(cpuHold), 64'd0);
        check("rst_done", 64'(loadDone), 64'd0);
        check("rst_error", 64'(loadError), 64'd0);
    endtask

    initial begin
        logic [IW-1:0] w;
        logic [7:0]    noise[3];
        int            nb;

        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs(1'b0);
        isResetN = 1'b1;
        @(posedge clock);
        #1;
        check_reset_outputs(1'b1);

        // Idle noise: discarded, no hold, no writes.
        noise[0] = 8'h00; noise[1] = 8'hFF; noise[2] = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            send_byte(noise[i], 1'b0);
            check("idle_hold", 64'(cpuHold), 64'd0);
            check("idle_we", 64'(memWriteEnable), 64'd0);
        end

        // Known good frame (checksum 0x64), then the same with 0x65.
        frame_words.push_back(32'h11223344);
        frame_words.push_back(32'h55667788);
        send_frame(2, 1'b0, 1'b0);
        frame_words.push_back(32'h11223344);
        frame_words.push_back(32'h55667788);
        send_frame(2, 1'b1, 1'b0);

        // Error noise is discarded, then a good frame recovers.
        send_byte(8'h3C, 1'b0);
        check("error_noise_hold", 64'(cpuHold), 64'd1);
        send_frame($urandom_range(1, 4), 1'b0, 1'b0);

        // Gapped 3-word frame.
        send_frame(3, 1'b0, 1'b1);

        // Full 256-word frame at full rate.
        send_frame(0, 1'b0, 1'b0);

        // Reset after 5 payload bytes: only the first word gets written.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h03, 1'b0);
        w = $urandom;
        wq.push_back({PW'(0), w});
        for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8], 1'b0);
        send_byte(8'hA5, 1'b0);
        isResetN = 1'b0;
        @(posedge clock);
        #1;
        check_reset_outputs(1'b0);
        isResetN = 1'b1;
        @(posedge clock);
        #1;
        check_reset_outputs(1'b1);
        send_frame(3, 1'b0, 1'b1);

        // Randomized frames, some corrupt.
        for (int f = 0; f < 5; f++) begin
            send_frame($urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        send_frame(2, 1'b0, 1'b1);

        repeat (4) @(posedge clock);
        #1;
        nb = wq.size();
        check("writes_outstanding", 64'(nb), 64'd0);
        check("done_count", 64'(done_seen), 64'(done_expected));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Loads a program image into the CPU's instruction memory from a byte stream while holding the CPU in reset. It sits between a byte source (a UART receiver or debug port) and the write port of instruction memory, which the CPU fetch path reads via `pc`. Its `cpuHold` output is ORed into the CPU's `isReset`. The CPU restarts from `pc = 0` once a load completes with a valid checksum.

## Interface
- `INSTRUCTION_WIDTH`, 32: instruction word width; must be a multiple of 8.
- `PC_WIDTH`, 8: instruction memory address width; depth is 2^PC_WIDTH.
- `START_BYTE`, 8'hA5: frame start marker.
- `clock` input 1: single clock; all logic is on its rising edge.
- `isResetN` input 1: reset, synchronous and active-low.
- `rxData` input 8: incoming byte.
- `rxValid` input 1: `rxData` is valid this cycle.
- `rxReady` output 1: loader accepts a byte this cycle.
- `memWriteEnable` output 1: one-cycle instruction-memory write strobe.
- `memAddress` output PC_WIDTH: write address.
- `memWriteData` output INSTRUCTION_WIDTH: write data.
- `cpuHold` output 1: hold the CPU in reset.
- `loadDone` output 1: one-cycle pulse on a successful load.
- `loadError` output 1: level; the last frame failed its checksum.

## Operation
- A byte is accepted on any cycle where `rxValid & rxReady`.
- Frame format: START_BYTE, then length byte N, then N words, then checksum byte.
  - Each word is sent as INSTRUCTION_WIDTH/8 bytes, most-significant byte first.
  - N = 0 means 2^PC_WIDTH words, capped at 256.
  - The checksum is the 8-bit modulo-256 sum of all payload bytes only. The start and length bytes are excluded.
- State machine states: IDLE, LENGTH, DATA, CHECK, DONE, ERROR.
- IDLE:
  - Non-start bytes are discarded.
  - START_BYTE → LENGTH.
  - On START_BYTE: set `cpuHold` = 1, clear `loadError`, clear the checksum, and set the word counter and address to 0.
- LENGTH: the accepted byte is latched as the word count → DATA.
- DATA:
  - Each accepted byte is shifted into the word assembler and added to the checksum.
  - On the last byte of a word, the write is issued and the address increments.
  - After the last byte of word N → CHECK.
- CHECK:
  - Accepted byte equals the running sum → DONE.
  - Otherwise → ERROR.
- DONE: `loadDone` = 1 and `cpuHold` = 0 for exactly one cycle → IDLE.
- ERROR:
  - `loadError` = 1 and `cpuHold` stays 1.
  - Non-start bytes are discarded.
  - START_BYTE restarts exactly as from IDLE.
- A START_BYTE value inside LENGTH, DATA or CHECK is treated as data. There is no in-band resynchronisation.
- Words already written before a checksum error remain in memory. Memory contents are undefined until a successful reload.

## Timing
- Reset values: state = IDLE; `rxReady` = 0 during the reset cycle and 1 from the first cycle after reset.
  - `memWriteEnable` = 0, `memAddress` = 0, `memWriteData` = 0.
  - `cpuHold` = 0, `loadDone` = 0, `loadError` = 0.
  - With `cpuHold` = 0 after reset, the CPU runs the preloaded image.
- `rxReady` = 1 in IDLE, LENGTH, DATA, CHECK and ERROR, and 0 in DONE.
- Write latency:
  - `memWriteEnable` is registered and asserts the cycle after the last byte of a word is accepted.
  - `memAddress` and `memWriteData` are stable during that cycle.
  - The address increments after the strobe.
- Back-to-back accepted bytes are supported at full rate, one byte per cycle, including across word boundaries.
- `loadDone` asserts the cycle after the correct checksum byte is accepted. `cpuHold` deasserts in that same cycle.
- `cpuHold` asserts the cycle after START_BYTE is accepted.
- Reset mid-frame: reset wins. All outputs return to their reset values and partial memory writes remain.
- Address wrap: with N = 0 and PC_WIDTH = 8, the final write is to address 255 and no write wraps to 0.

## Structure
- Package `loader_pkg`:
  - state enum `loader_state_t`;
  - START_BYTE default;
  - localparam `BYTES_PER_WORD` = INSTRUCTION_WIDTH/8.
- Sub-module `loader_word_packer`:
  - shift register plus byte counter;
  - inputs: `clock`, `isResetN`, `clear`, `byteValid`, `byte`;
  - outputs: `word`, `wordValid`.
- The FSM, checksum, word counter and address counter live in `program_loader`.

## Test plan
- Good frame: A5, 02, then 11 22 33 44 and 55 66 77 88, then checksum 0x64.
  - Required: writes of 0x11223344 to address 0 and 0x55667788 to address 1.
  - Required: one `loadDone` pulse; `cpuHold` high from the cycle after A5 until `loadDone`.
- Bad checksum: same frame with checksum 0x65.
  - Required: `loadError` = 1, `cpuHold` stays 1, no `loadDone`.
  - A following good frame clears `loadError` and completes.
- Idle noise: bytes 00, FF, 5A in IDLE.
  - Required: no writes; `cpuHold` stays 0.
- Full-rate plus gaps: `rxValid` toggled randomly over a 3-word frame.
  - Required: exactly 3 strobes with correct data; addresses 0, 1, 2.
- N = 0 frame: 256 words.
  - Required: last write to address 255; `loadDone` asserts.
- Reset mid-DATA: `isResetN` = 0 for 1 cycle after 5 payload bytes.
  - Required: all outputs take their reset values; the next full frame loads correctly.
